// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the single register-file write port among NREQ writeback sources.
// Optional same-cycle forwarding of the registered write is enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wa,
  output logic [DW-1:0]      rf_wd,
`ifdef RF_WB_FWD_EN
  input  logic [AW-1:0]      fwd_ra1,
  input  logic [AW-1:0]      fwd_ra2,
  output logic               fwd1_hit,
  output logic               fwd2_hit,
  output logic [DW-1:0]      fwd1_data,
  output logic [DW-1:0]      fwd2_data,
`endif
  output logic               busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_wa_q, rf_wa_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;
  logic          busy_q, busy_d;

  logic          xfer;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   scan;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Scan from rr_ptr with wraparound; the first valid requester wins. Address/data only feed the mux.
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    sel_addr  = '0;
    sel_data  = '0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        scan = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
        if (!xfer && req_valid[scan[PW-1:0]]) begin
          xfer    = 1'b1;
          gnt_idx = scan[PW-1:0];
        end
      end
      if (xfer) req_ready[gnt_idx] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Writes to r0 are consumed and advance the pointer but never reach the regfile.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rf_we_d  = 1'b0;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;
    busy_d   = |req_valid;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
      if (sel_addr != '0) begin
        rf_we_d = 1'b1;
        rf_wa_d = sel_addr;
        rf_wd_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rf_we_q  <= rf_we_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
      busy_q   <= busy_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;
  assign busy  = busy_q;

`ifdef RF_WB_FWD_EN
  // Bridges the half cycle before the regfile commits on the falling edge.
  assign fwd1_hit  = rf_we_q && (rf_wa_q == fwd_ra1) && (fwd_ra1 != '0);
  assign fwd2_hit  = rf_we_q && (rf_wa_q == fwd_ra2) && (fwd_ra2 != '0);
  assign fwd1_data = fwd1_hit ? rf_wd_q : '0;
  assign fwd2_data = fwd2_hit ? rf_wd_q : '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, forwarding case, randomized run vs model.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_we;
  logic [AW-1:0]      rf_wa;
  logic [DW-1:0]      rf_wd;
  logic               busy;
`ifdef RF_WB_FWD_EN
  logic [AW-1:0]      fwd_ra1, fwd_ra2;
  logic               fwd1_hit, fwd2_hit;
  logic [DW-1:0]      fwd1_data, fwd2_data;
`endif

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
`ifdef RF_WB_FWD_EN
    .fwd_ra1(fwd_ra1), .fwd_ra2(fwd_ra2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: the round-robin "next in line" index and the registered write.
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic          m_busy;

  logic [NREQ-1:0] obs_ready;
  logic            obs_we;
  logic [AW-1:0]   obs_wa;
  logic [DW-1:0]   obs_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Called 1 time unit after a posedge; returns 1 time unit after the next posedge.
  task automatic apply(input logic r, input logic [NREQ-1:0] v,
                       input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
    int g;
    logic [NREQ-1:0] exp_rdy;
    rst = r; req_valid = v; req_addr = a; req_data = d;
    #3;
    g = r ? -1 : model_pick(v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_ready = req_ready;
    chk("ready", 32'(req_ready), 32'(exp_rdy));
    if (r) begin
      m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_busy = 1'b0;
    end else begin
      m_busy = |v;
      m_we   = 1'b0;
      if (g >= 0) begin
        m_ptr = (g + 1) % NREQ;
        if (a[g*AW +: AW] != '0) begin
          m_we = 1'b1;
          m_wa = a[g*AW +: AW];
          m_wd = d[g*DW +: DW];
        end
      end
    end
    @(posedge clk);
    #1;
    obs_we = rf_we; obs_wa = rf_wa; obs_wd = rf_wd;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_wa", 32'(rf_wa), 32'(m_wa));
    chk("rf_wd", rf_wd, m_wd);
    chk("busy", 32'(busy), 32'(m_busy));
`ifdef RF_WB_FWD_EN
    begin
      logic h1, h2;
      h1 = m_we && (m_wa == fwd_ra1) && (fwd_ra1 != '0);
      h2 = m_we && (m_wa == fwd_ra2) && (fwd_ra2 != '0);
      chk("fwd1_hit", 32'(fwd1_hit), 32'(h1));
      chk("fwd2_hit", 32'(fwd2_hit), 32'(h2));
      chk("fwd1_data", fwd1_data, h1 ? m_wd : 32'h0);
      chk("fwd2_data", fwd2_data, h2 ? m_wd : 32'h0);
    end
`endif
  endtask

  typedef struct {
    logic               r;
    logic [NREQ-1:0]    v;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    rdy;
    logic               we;
    logic [AW-1:0]      wa;
    logic [DW-1:0]      wd;
  } vec_t;

  vec_t vecs[16];

  logic [NREQ-1:0]    cur_v;
  logic [AW-1:0]      cur_a [NREQ];
  logic [DW-1:0]      cur_d [NREQ];
  int                 wait_cnt [NREQ];
  logic               r_rnd;
  logic [NREQ*AW-1:0] a_rnd;
  logic [NREQ*DW-1:0] d_rnd;

  initial begin
    // Directed sequence: reset with all valid, rotation over 1/2/3, single write,
    // write to r0, pointer effect on a 0+2 pair, reset right after an accept.
    vecs[0]  = '{1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b000, 1'b0, 5'd0, 32'h0};
    vecs[1]  = '{1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b000, 1'b0, 5'd0, 32'h0};
    vecs[2]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b001, 1'b1, 5'd1, 32'h11};
    vecs[3]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b010, 1'b1, 5'd2, 32'h22};
    vecs[4]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b100, 1'b1, 5'd3, 32'h33};
    vecs[5]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b001, 1'b1, 5'd1, 32'h11};
    vecs[6]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b010, 1'b1, 5'd2, 32'h22};
    vecs[7]  = '{1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b100, 1'b1, 5'd3, 32'h33};
    vecs[8]  = '{1'b0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 3'b000, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0}, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 3'b001, 1'b0, 5'd5, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 3'b101, {5'd4, 5'd0, 5'd6}, {32'h44, 32'h0, 32'h66}, 3'b100, 1'b1, 5'd4, 32'h44};
    vecs[12] = '{1'b0, 3'b001, {5'd4, 5'd0, 5'd6}, {32'h44, 32'h0, 32'h66}, 3'b001, 1'b1, 5'd6, 32'h66};
    vecs[13] = '{1'b0, 3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0}, 3'b100, 1'b1, 5'd7, 32'h77};
    vecs[14] = '{1'b1, 3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0}, 3'b000, 1'b0, 5'd0, 32'h0};
    vecs[15] = '{1'b0, 3'b010, {5'd0, 5'd8, 5'd0}, {32'h0, 32'h88, 32'h0}, 3'b010, 1'b1, 5'd8, 32'h88};

    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
`ifdef RF_WB_FWD_EN
    fwd_ra1 = '0; fwd_ra2 = '0;
`endif
    m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_busy = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].d);
      chk($sformatf("tbl%0d_ready", i), 32'(obs_ready), 32'(vecs[i].rdy));
      chk($sformatf("tbl%0d_we", i), 32'(obs_we), 32'(vecs[i].we));
      chk($sformatf("tbl%0d_wa", i), 32'(obs_wa), 32'(vecs[i].wa));
      chk($sformatf("tbl%0d_wd", i), obs_wd, vecs[i].wd);
    end

`ifdef RF_WB_FWD_EN
    fwd_ra1 = 5'd9; fwd_ra2 = 5'd0;
    apply(1'b0, 3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'hCAFE0001});
    chk("fwd_case_hit1", 32'(fwd1_hit), 32'h1);
    chk("fwd_case_data1", fwd1_data, 32'hCAFE0001);
    chk("fwd_case_hit2", 32'(fwd2_hit), 32'h0);
`endif

    // Randomized: requesters mostly hold a pending write until granted, sometimes drop it.
    cur_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      cur_a[i] = '0; cur_d[i] = '0; wait_cnt[i] = 0;
    end
    obs_ready = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(cur_v[i] && !obs_ready[i] && $urandom_range(0, 9) != 0)) begin
          cur_v[i] = 1'($urandom_range(0, 1));
          cur_a[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
          cur_d[i] = $urandom;
        end
        a_rnd[i*AW +: AW] = cur_a[i];
        d_rnd[i*DW +: DW] = cur_d[i];
      end
      r_rnd = ($urandom_range(0, 39) == 0);
`ifdef RF_WB_FWD_EN
      fwd_ra1 = $urandom_range(0, 1) ? m_wa : AW'($urandom_range(0, 31));
      fwd_ra2 = AW'($urandom_range(0, 31));
`endif
      apply(r_rnd, cur_v, a_rnd, d_rnd);
      for (int i = 0; i < NREQ; i++) begin
        if (r_rnd || !cur_v[i]) begin
          wait_cnt[i] = 0;
        end else if (obs_ready[i]) begin
          chk($sformatf("starve_bound%0d", i), 32'(wait_cnt[i] < NREQ), 32'h1);
          wait_cnt[i] = 0;
        end else begin
          wait_cnt[i]++;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
